// File: rtl/dvp_pkg.sv
// dvp_pkg: shared types and constants for the DVP capture path.
//   cap_state_t       : capture FSM state encoding
//   rgb565_t          : one RGB565 pixel word
//   DVP_BYTES_PER_PIX : sensor bytes that make up one pixel
package dvp_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_SYNC   = 2'd1,
    CAP_ACTIVE = 2'd2
  } cap_state_t;

  typedef logic [15:0] rgb565_t;

  localparam int DVP_BYTES_PER_PIX = 2;

endpackage

// File: rtl/dvp_byte_pack.sv
// dvp_byte_pack: pairs consecutive sensor bytes into one RGB565 word.
//   clk, rst_n : pixel clock, async active-low reset
//   clr        : drop any half-assembled pixel and return to byte phase 0
//   byte_en    : byte_in carries a valid sensor byte this cycle
//   byte_in    : sensor byte (already registered by the caller)
//   word       : assembled pixel, meaningful while strobe is high
//   strobe     : second byte of a pair is present, word is complete
//   phase      : current byte phase (1 = half pixel held)
// BYTE_SWAP = 0 puts the first byte in word[15:8], 1 puts it in word[7:0].
module dvp_byte_pack
  import dvp_pkg::*;
#(
  parameter int BYTE_SWAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       byte_en,
  input  logic [7:0] byte_in,
  output rgb565_t    word,
  output logic       strobe,
  output logic       phase
);

  localparam logic LAST_PHASE = 1'(DVP_BYTES_PER_PIX - 1);

  logic [7:0] hold_r;
  logic       phase_r;

  // Hold register for the first byte and the byte-phase toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r  <= 8'h00;
      phase_r <= 1'b0;
    end else if (clr) begin
      phase_r <= 1'b0;
    end else if (byte_en) begin
      if (phase_r == 1'b0) begin
        hold_r <= byte_in;
      end else begin
        hold_r <= hold_r;
      end
      phase_r <= ~phase_r;
    end else begin
      phase_r <= phase_r;
    end
  end

  // Word assembly: the second byte is combined straight from the input.
  always_comb begin
    word   = {hold_r, byte_in};
    strobe = byte_en & ~clr & (phase_r == LAST_PHASE);
    if (BYTE_SWAP != 0) begin
      word = {byte_in, hold_r};
    end else begin
      word = {hold_r, byte_in};
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/dvp_capture.sv
// dvp_capture: DVP camera receive stage. Captures whole frames only and emits
// RGB565 pixels with start-of-frame / end-of-line markers.
//   clk, rst_n   : sensor pixel clock, async active-low reset
//   enable       : capture request, acted on at frame boundaries only
//   dvp_vsync    : sensor vsync (polarity set by VSYNC_POL)
//   dvp_de       : sensor data enable (href)
//   dvp_data     : sensor byte
//   err_clr      : pulse, clears err_line / err_frame (a new error wins)
//   pix_data     : RGB565 pixel, pix_valid qualifies it
//   pix_sof      : first pixel of frame, pix_eol : last pixel of line
//   frame_done   : pulse, a frame with exactly V_ACTIVE lines ended
//   busy         : capture FSM in ACTIVE
//   err_line     : sticky, a line was not exactly 2*H_ACTIVE bytes
//   err_frame    : sticky, a frame did not have V_ACTIVE lines
//   frame_cnt    : completed-frame counter
// Optional feature macro DVP_CAPTURE_STATS_EN: when defined frame_cnt counts
// frame_done pulses (wrapping); otherwise frame_cnt is constant zero.
// Pixel latency: second byte of a pair sampled on edge N -> pix_valid after N+2.
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_POL = 1,
  parameter int BYTE_SWAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        dvp_vsync,
  input  logic        dvp_de,
  input  logic [7:0]  dvp_data,
  input  logic        err_clr,
  output rgb565_t     pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        busy,
  output logic        err_line,
  output logic        err_frame,
  output logic [15:0] frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);

  logic          vsync_q_r, vsync_d_r, de_q_r, de_d_r;
  logic [7:0]    data_q_r;
  cap_state_t    state_r, state_nx_s;
  logic          start_s, active_s, vs_rise_s, vs_fall_s, de_fall_s;
  logic          line_end_s, frame_end_s, line_bad_s;
  logic          frame_good_s, frame_bad_s, frame_ovf_post_s;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r, y_inc_s, y_post_s;
  logic          line_ovf_r, frame_ovf_r;
  logic          pack_clr_s, pack_en_s, strobe_s, phase_s, pix_acc_s, pix_drop_s;
  rgb565_t       word_s;
  logic          s1_valid_r, s1_sof_r, s1_eol_r;
  rgb565_t       s1_data_r;

  // Input register stage plus delayed copies for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q_r <= 1'b0;
      vsync_d_r <= 1'b0;
      de_q_r    <= 1'b0;
      de_d_r    <= 1'b0;
      data_q_r  <= 8'h00;
    end else begin
      vsync_q_r <= (VSYNC_POL != 0) ? dvp_vsync : ~dvp_vsync;
      vsync_d_r <= vsync_q_r;
      de_q_r    <= dvp_de;
      de_d_r    <= de_q_r;
      data_q_r  <= dvp_data;
    end
  end

  assign vs_rise_s   = vsync_q_r & ~vsync_d_r;
  assign vs_fall_s   = ~vsync_q_r & vsync_d_r;
  assign de_fall_s   = ~de_q_r & de_d_r;
  assign active_s    = (state_r == CAP_ACTIVE);
  assign line_end_s  = active_s & de_fall_s;
  assign frame_end_s = active_s & vs_rise_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CAP_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: ACTIVE is only entered on a vsync deassert edge.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    case (state_r)
      CAP_IDLE: begin
        if (enable) state_nx_s = CAP_SYNC;
        else        state_nx_s = CAP_IDLE;
      end
      CAP_SYNC: begin
        if (vs_fall_s) begin
          if (enable) begin
            state_nx_s = CAP_ACTIVE;
            start_s    = 1'b1;
          end else begin
            state_nx_s = CAP_IDLE;
          end
        end else begin
          state_nx_s = CAP_SYNC;
        end
      end
      CAP_ACTIVE: begin
        if (vs_rise_s) state_nx_s = CAP_SYNC;
        else           state_nx_s = CAP_ACTIVE;
      end
      default: begin
        state_nx_s = CAP_IDLE;
      end
    endcase
  end

  // A half pixel still open at line end or frame end is thrown away.
  assign pack_clr_s = start_s | line_end_s | frame_end_s;
  assign pack_en_s  = active_s & de_q_r;

  dvp_byte_pack #(.BYTE_SWAP(BYTE_SWAP)) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pack_clr_s),
    .byte_en (pack_en_s),
    .byte_in (data_q_r),
    .word    (word_s),
    .strobe  (strobe_s),
    .phase   (phase_s)
  );

  assign pix_acc_s  = strobe_s & (x_r < X_END) & (y_r < Y_END);
  assign pix_drop_s = strobe_s & ~pix_acc_s;

  // Line close happens before the frame-end compare when both land together.
  // Overflow flags remember lines/pixels lost to counter saturation.
  assign line_bad_s       = line_end_s & ((x_r != X_END) | line_ovf_r | phase_s);
  assign y_inc_s          = (y_r == Y_END) ? y_r : (y_r + YW'(1));
  assign y_post_s         = line_end_s ? y_inc_s : y_r;
  assign frame_ovf_post_s = frame_ovf_r | (line_end_s & (y_r == Y_END));
  assign frame_good_s     = frame_end_s & (y_post_s == Y_END) & ~frame_ovf_post_s;
  assign frame_bad_s      = frame_end_s & ~frame_good_s;

  // Pixel / line counters with saturation and overflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r         <= '0;
      y_r         <= '0;
      line_ovf_r  <= 1'b0;
      frame_ovf_r <= 1'b0;
    end else if (start_s) begin
      x_r         <= '0;
      y_r         <= '0;
      line_ovf_r  <= 1'b0;
      frame_ovf_r <= 1'b0;
    end else if (line_end_s) begin
      x_r         <= '0;
      y_r         <= y_post_s;
      line_ovf_r  <= 1'b0;
      frame_ovf_r <= frame_ovf_post_s;
    end else if (pix_acc_s) begin
      x_r <= x_r + XW'(1);
    end else if (pix_drop_s) begin
      line_ovf_r <= 1'b1;
    end else begin
      x_r <= x_r;
    end
  end

  // Pixel pipeline: markers captured with the accept, then the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 16'h0000;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= 16'h0000;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
    end else begin
      s1_valid_r <= pix_acc_s;
      s1_data_r  <= pix_acc_s ? word_s : 16'h0000;
      s1_sof_r   <= pix_acc_s & (x_r == '0) & (y_r == '0);
      s1_eol_r   <= pix_acc_s & (x_r == X_LAST);
      pix_valid  <= s1_valid_r;
      pix_data   <= s1_data_r;
      pix_sof    <= s1_sof_r;
      pix_eol    <= s1_eol_r;
    end
  end

  // Status outputs; a new error takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_line   <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      frame_done <= frame_good_s;
      busy       <= (state_nx_s == CAP_ACTIVE);
      err_line   <= line_bad_s  ? 1'b1 : (err_clr ? 1'b0 : err_line);
      err_frame  <= frame_bad_s ? 1'b1 : (err_clr ? 1'b0 : err_frame);
    end
  end

`ifdef DVP_CAPTURE_STATS_EN
  // Completed-frame counter, wraps at 16 bits, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'h0000;
    end else if (frame_good_s) begin
      frame_cnt <= frame_cnt + 16'h0001;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Testbench for dvp_capture with a 4x2 frame. Two instances share stimulus:
// "dut" with BYTE_SWAP=0 and "dut_sw" with BYTE_SWAP=1.
module tb_dvp_capture;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        dvp_vsync = 1'b0;
  logic        dvp_de = 1'b0;
  logic [7:0]  dvp_data = 8'h00;
  logic        err_clr = 1'b0;

  logic [15:0] pix_data, sw_pix_data, frame_cnt, sw_frame_cnt;
  logic        pix_valid, pix_sof, pix_eol, frame_done, busy, err_line, err_frame;
  logic        sw_pix_valid, sw_pix_sof, sw_pix_eol, sw_frame_done, sw_busy;
  logic        sw_err_line, sw_err_frame;

  dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1), .BYTE_SWAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dvp_vsync(dvp_vsync),
    .dvp_de(dvp_de), .dvp_data(dvp_data), .err_clr(err_clr),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .frame_done(frame_done), .busy(busy),
    .err_line(err_line), .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .VSYNC_POL(1), .BYTE_SWAP(1)) dut_sw (
    .clk(clk), .rst_n(rst_n), .enable(enable), .dvp_vsync(dvp_vsync),
    .dvp_de(dvp_de), .dvp_data(dvp_data), .err_clr(err_clr),
    .pix_data(sw_pix_data), .pix_valid(sw_pix_valid), .pix_sof(sw_pix_sof),
    .pix_eol(sw_pix_eol), .frame_done(sw_frame_done), .busy(sw_busy),
    .err_line(sw_err_line), .err_frame(sw_err_frame), .frame_cnt(sw_frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the inactive clock edge.
  logic [15:0] pd_q[$];
  logic [15:0] sw_q[$];
  logic        sof_q[$];
  logic        eol_q[$];
  int          fd_cnt = 0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pd_q.push_back(pix_data);
      sof_q.push_back(pix_sof);
      eol_q.push_back(pix_eol);
    end
    if (sw_pix_valid) sw_q.push_back(sw_pix_data);
    if (frame_done) fd_cnt++;
  end

  // Byte i of a line starting at base.
  function automatic logic [7:0] bt(input logic [7:0] base, input int i);
    return base + 8'(i * 34);
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input int nb, input logic [7:0] base);
    for (int i = 0; i < nb; i++) begin
      dvp_de   = 1'b1;
      dvp_data = bt(base, i);
      tick(1);
    end
    dvp_de   = 1'b0;
    dvp_data = 8'h00;
    tick(4);
  endtask

  task automatic vs_pulse();
    dvp_vsync = 1'b1;
    tick(3);
    dvp_vsync = 1'b0;
    tick(3);
  endtask

  task automatic good_frame(input logic [7:0] base);
    send_line(2 * H, base);
    send_line(2 * H, base + 8'h01);
    vs_pulse();
  endtask

  // Checks the 8 pixels of a good frame starting at queue index i0.
  task automatic check_frame(input string tag, input int i0, input logic [7:0] b0);
    logic [7:0] b;
    int k;
    for (int l = 0; l < V; l++) begin
      b = (l == 0) ? b0 : b0 + 8'h01;
      for (int p = 0; p < H; p++) begin
        k = i0 + l * H + p;
        chk($sformatf("%s_data%0d", tag, k - i0), pd_q[k], {bt(b, 2 * p), bt(b, 2 * p + 1)});
        chk($sformatf("%s_swap%0d", tag, k - i0), sw_q[k], {bt(b, 2 * p + 1), bt(b, 2 * p)});
        chk($sformatf("%s_sof%0d", tag, k - i0), sof_q[k], (l == 0 && p == 0) ? 1 : 0);
        chk($sformatf("%s_eol%0d", tag, k - i0), eol_q[k], (p == H - 1) ? 1 : 0);
      end
    end
  endtask

  int i0, f0;
  logic [15:0] c0;
  logic [15:0] fc_exp;

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", pix_valid, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_errl", err_line, 0);
    chk("rst_errf", err_frame, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(2);
    vs_pulse();
    chk("t1_busy", busy, 1);

    // T1: basic 4x2 frame, 0x12,0x34 -> 0x1234
    i0 = pd_q.size(); f0 = fd_cnt;
    good_frame(8'h12);
    chk("t1_npix", pd_q.size() - i0, 8);
    chk("t1_nswap", sw_q.size() - i0, 8);
    chk("t1_fdone", fd_cnt - f0, 1);
    check_frame("t1", i0, 8'h12);
    chk("t1_errl", err_line, 0);
    chk("t1_errf", err_frame, 0);

    // T2: latency, bytes 0xAB,0xCD -> 0xABCD / swapped 0xCDAB
    i0 = pd_q.size(); f0 = fd_cnt;
    for (int i = 0; i < 2 * H; i++) begin
      dvp_de   = 1'b1;
      dvp_data = bt(8'hAB, i);
      tick(1);
      if (i == 1) chk("t2_lat_n0", pix_valid, 0);
      if (i == 2) chk("t2_lat_n1", pix_valid, 0);
      if (i == 3) begin
        chk("t2_lat_n2", pix_valid, 1);
        chk("t2_lat_data", pix_data, 16'hABCD);
        chk("t2_lat_swap", sw_pix_data, 16'hCDAB);
      end
      if (i == 4) chk("t2_lat_n3", pix_valid, 0);
    end
    dvp_de = 1'b0;
    tick(4);
    send_line(2 * H, 8'hAC);
    vs_pulse();
    chk("t2_npix", pd_q.size() - i0, 8);
    chk("t2_fdone", fd_cnt - f0, 1);
    check_frame("t2", i0, 8'hAB);

    // T3: enable dropped in a frame, then raised mid-frame
    enable = 1'b0;
    i0 = pd_q.size(); f0 = fd_cnt;
    good_frame(8'h30);
    chk("t3_drop_npix", pd_q.size() - i0, 8);
    chk("t3_drop_fdone", fd_cnt - f0, 1);
    chk("t3_idle_busy", busy, 0);
    i0 = pd_q.size(); f0 = fd_cnt;
    send_line(2 * H, 8'h40);
    enable = 1'b1;
    tick(1);
    send_line(2 * H, 8'h41);
    chk("t3_mid_npix", pd_q.size() - i0, 0);
    chk("t3_mid_busy", busy, 0);
    vs_pulse();
    chk("t3_mid_fdone", fd_cnt - f0, 0);
    chk("t3_resync_busy", busy, 1);
    i0 = pd_q.size(); f0 = fd_cnt;
    good_frame(8'h50);
    chk("t3_npix", pd_q.size() - i0, 8);
    chk("t3_fdone", fd_cnt - f0, 1);
    check_frame("t3", i0, 8'h50);

    // T4: short line (7 bytes) and long line (10 bytes)
    i0 = pd_q.size();
    send_line(7, 8'h60);
    chk("t4_short_errl", err_line, 1);
    chk("t4_short_npix", pd_q.size() - i0, 3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t4_clr_errl", err_line, 0);
    send_line(10, 8'h70);
    chk("t4_long_errl", err_line, 1);
    chk("t4_long_npix", pd_q.size() - i0, 7);
    chk("t4_long_last", pd_q[i0 + 6], {bt(8'h70, 6), bt(8'h70, 7)});
    chk("t4_long_eol", eol_q[i0 + 6], 1);
    chk("t4_errf", err_frame, 0);
    vs_pulse();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("t4_clr2_errl", err_line, 0);

    // T5: frame with a single line
    f0 = fd_cnt;
    c0 = frame_cnt;
    send_line(2 * H, 8'h80);
    vs_pulse();
    chk("t5_errf", err_frame, 1);
    chk("t5_fdone", fd_cnt - f0, 0);
    chk("t5_fcnt_hold", frame_cnt, c0);
`ifndef DVP_CAPTURE_STATS_EN
    chk("t5_fcnt_zero", frame_cnt, 0);
`endif

    // T6: reset in the middle of a line
    i0 = pd_q.size();
    for (int i = 0; i < 4; i++) begin
      dvp_de   = 1'b1;
      dvp_data = bt(8'h88, i);
      tick(1);
    end
    chk("t6_pre_valid", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", pix_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_errf", err_frame, 0);
    chk("t6_rst_fcnt", frame_cnt, 0);
    rst_n = 1'b1;
    i0 = pd_q.size(); f0 = fd_cnt;
    for (int i = 4; i < 2 * H; i++) begin
      dvp_de   = 1'b1;
      dvp_data = bt(8'h88, i);
      tick(1);
    end
    dvp_de = 1'b0;
    tick(4);
    send_line(2 * H, 8'h89);
    chk("t6_nosync_npix", pd_q.size() - i0, 0);
    vs_pulse();
    good_frame(8'h90);
    good_frame(8'hA0);
    good_frame(8'hB0);
    chk("t6_npix", pd_q.size() - i0, 24);
    chk("t6_fdone", fd_cnt - f0, 3);
    check_frame("t6", i0, 8'h90);
`ifdef DVP_CAPTURE_STATS_EN
    fc_exp = 16'd3;
`else
    fc_exp = 16'd0;
`endif
    chk("t6_fcnt", frame_cnt, fc_exp);
    chk("t6_errf", err_frame, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
